// File: rtl/radix_16_multiplier_uint.sv
// radix_16_multiplier_uint: sequential unsigned multiplier, 4 multiplier bits per cycle.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   enable_input  start request, accepted when not busy
//   multiplicand  operand A, latched on the accepting edge
//   multiplier    operand B, latched on the accepting edge
//   product       full 2*WIDTH product, valid while done=1, held until next acceptance
//   done          one-cycle completion pulse
//   busy          high whenever the FSM is not idle
module radix_16_multiplier_uint #(
   parameter  int unsigned WIDTH = 24,
   localparam int unsigned PW    = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_input,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic [PW-1:0]    product,
   output logic             done,
   output logic             busy
);

   localparam int unsigned DIGITS = WIDTH / 4;
   localparam int unsigned MW     = WIDTH + 4;
   localparam int unsigned IW     = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, ITER} state_t;

   state_t           state, state_nxt;
   logic             done_nxt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [MW-1:0]    m   [16];
   logic [MW-1:0]    m_c [16];
   logic [IW-1:0]    it;
   logic             zero_c, last_c;
   logic [MW-1:0]    sum_c;

   // Multiples table k*A: even entries are a doubled half entry, odd ones add A once more
   always_comb begin
      m_c[0] = '0;
      for (int k = 1; k < 16; k++) begin
         if (k % 2 == 0) m_c[k] = m_c[4'(k / 2)] << 1;
         else            m_c[k] = m_c[4'(k - 1)] + MW'(a_q);
      end
   end

   assign zero_c = (a_q == '0) || (b_q == '0);
   assign last_c = (it == IW'(1));
   // Upper half of the accumulator plus the selected multiple; WIDTH+4 bits cannot overflow
   assign sum_c  = MW'(product[PW-1:WIDTH]) + m[b_q[3:0]];
   assign busy   = (state != IDLE);

   // Next-state and completion pulse
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: if (enable_input) state_nxt = LOAD;
         LOAD: begin
            if (zero_c) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = ITER;
            end
         end
         ITER: begin
            if (last_c) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Datapath: operand latch, table build, shift-add accumulation in the product register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         it      <= '0;
         product <= '0;
         for (int k = 0; k < 16; k++) m[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable_input) begin
                  a_q     <= multiplicand;
                  b_q     <= multiplier;
                  product <= '0;
               end
            end
            LOAD: begin
               m  <= m_c;
               it <= IW'(DIGITS);
               if (zero_c) product <= '0;
            end
            ITER: begin
               product <= {sum_c, product[WIDTH-1:4]};
               b_q     <= b_q >> 4;
               it      <= it - IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
